// File: rtl/decode_pkg.sv
// Shared types and constants for the RV32 decode stage.
package decode_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned PREG_W = 5;
  localparam int unsigned ILEN   = 32;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned F7_W   = 7;

  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_BRU = 2'd1,
    FU_LSU = 2'd2
  } fu_t;

  // Immediate format selector driven by the field decoder into imm_gen.
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4
  } imm_sel_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [OPC_W-1:0]  opcode;
    logic [PREG_W-1:0] rd;
    logic [PREG_W-1:0] rs1;
    logic [PREG_W-1:0] rs2;
    logic [F3_W-1:0]   funct3;
    logic [F7_W-1:0]   funct7;
    logic [XLEN-1:0]   imm;
    fu_t               fu;
    logic              regwrite;
    logic              uses_rs1;
    logic              uses_rs2;
    logic              is_load;
    logic              is_store;
    logic              is_branch;
    logic              is_jump;
    logic              illegal;
  } decoded_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32 immediate generator.
// Ports: instr  - instruction bits [31:7] (opcode bits not needed)
//        sel    - immediate format
//        imm_c  - sign-extended immediate (combinational)
module imm_gen
  import decode_pkg::*;
(
  input  logic [ILEN-1:7] instr,
  input  imm_sel_t        sel,
  output logic [XLEN-1:0] imm_c
);

  logic [11:0] i_raw;
  logic [11:0] s_raw;
  logic [12:0] b_raw;
  logic [31:0] u_raw;

  // Reassemble the scattered immediate bits for each format.
  always_comb begin
    i_raw = instr[31:20];
    s_raw = {instr[31:25], instr[11:7]};
    b_raw = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    u_raw = {instr[31:12], 12'b0};
  end

  // Select and sign-extend to XLEN.
  always_comb begin
    imm_c = '0;
    case (sel)
      IMM_I:   imm_c = XLEN'($signed(i_raw));
      IMM_S:   imm_c = XLEN'($signed(s_raw));
      IMM_B:   imm_c = XLEN'($signed(b_raw));
      IMM_U:   imm_c = XLEN'($signed(u_raw));
      default: imm_c = '0;
    endcase
  end

endmodule

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: a main register driving the output plus a skid
// register that absorbs one item while the consumer stalls. in_ready is a
// register, so there is no combinational path from out_ready to in_ready.
// Ports: clk, rst_n, flush (drop everything held)
//        in_valid/in_ready/in_data   - upstream handshake
//        out_valid/out_ready/out_data - downstream handshake
module skid_buffer #(
  parameter type T = logic [31:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic main_valid, main_valid_n;
  logic skid_valid, skid_valid_n;
  logic ready, ready_n;
  T     main_data, main_data_n;
  T     skid_data, skid_data_n;
  logic take;
  logic drain;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready      <= 1'b1;
      main_data  <= '0;
      skid_data  <= '0;
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
      ready      <= ready_n;
      main_data  <= main_data_n;
      skid_data  <= skid_data_n;
    end
  end

  // Next-state: skid always refills main before newer input, keeping order.
  always_comb begin
    main_valid_n = main_valid;
    main_data_n  = main_data;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    take         = in_valid && ready;
    drain        = !main_valid || out_ready;

    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        main_valid_n = 1'b1;
        main_data_n  = skid_data;
        skid_valid_n = 1'b0;
      end else begin
        main_valid_n = take;
        if (take) begin
          main_data_n = in_data;
        end
      end
    end else if (take) begin
      skid_valid_n = 1'b1;
      skid_data_n  = in_data;
    end

    ready_n = !skid_valid_n;
  end

  // Outputs come straight from registers.
  always_comb begin
    in_ready  = ready;
    out_valid = main_valid;
    out_data  = main_data;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32 decode stage between fetch and rename. Splits fields,
// builds the immediate, classifies FU/control and holds the packet in a
// two-entry skid buffer so back-pressure does not cost throughput.
// Ports: clk, rst_n, flush
//        in_valid/in_ready/in_instr/in_pc - from fetch
//        out_valid/out_ready/out_pkt      - to rename (decoded_t)
module decode_stage
  import decode_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output decoded_t        out_pkt
);

  logic [OPC_W-1:0]  opcode;
  logic [PREG_W-1:0] rd_eff;
  imm_sel_t          imm_sel;
  logic [XLEN-1:0]   imm;
  fu_t               fu;
  logic              rw;
  logic              use1;
  logic              use2;
  logic              ld;
  logic              st;
  logic              br;
  logic              jp;
  logic              ill;
  decoded_t          pkt;

  imm_gen u_imm_gen (
    .instr (in_instr[ILEN-1:7]),
    .sel   (imm_sel),
    .imm_c (imm)
  );

  // Opcode classification; unknown opcodes pass through flagged illegal.
  always_comb begin
    opcode  = in_instr[6:0];
    rd_eff  = in_instr[11:7];
    imm_sel = IMM_NONE;
    fu      = FU_ALU;
    rw      = 1'b0;
    use1    = 1'b0;
    use2    = 1'b0;
    ld      = 1'b0;
    st      = 1'b0;
    br      = 1'b0;
    jp      = 1'b0;
    ill     = 1'b0;
    case (opcode)
      OP_R: begin
        rw   = 1'b1;
        use1 = 1'b1;
        use2 = 1'b1;
      end
      OP_IMM: begin
        rw      = 1'b1;
        use1    = 1'b1;
        imm_sel = IMM_I;
      end
      OP_LUI: begin
        rw      = 1'b1;
        imm_sel = IMM_U;
      end
      OP_LOAD: begin
        fu      = FU_LSU;
        rw      = 1'b1;
        use1    = 1'b1;
        ld      = 1'b1;
        imm_sel = IMM_I;
      end
      OP_STORE: begin
        fu      = FU_LSU;
        use1    = 1'b1;
        use2    = 1'b1;
        st      = 1'b1;
        imm_sel = IMM_S;
        rd_eff  = '0;
      end
      OP_BRANCH: begin
        fu      = FU_BRU;
        use1    = 1'b1;
        use2    = 1'b1;
        br      = 1'b1;
        imm_sel = IMM_B;
        rd_eff  = '0;
      end
      OP_JALR: begin
        fu      = FU_BRU;
        rw      = 1'b1;
        use1    = 1'b1;
        jp      = 1'b1;
        imm_sel = IMM_I;
      end
      default: ill = 1'b1;
    endcase
  end

  // Packet assembly; x0 is never a real destination.
  always_comb begin
    pkt           = '0;
    pkt.pc        = in_pc;
    pkt.opcode    = opcode;
    pkt.rd        = rd_eff;
    pkt.rs1       = in_instr[19:15];
    pkt.rs2       = in_instr[24:20];
    pkt.funct3    = in_instr[14:12];
    pkt.funct7    = in_instr[31:25];
    pkt.imm       = imm;
    pkt.fu        = fu;
    pkt.regwrite  = rw && (rd_eff != '0);
    pkt.uses_rs1  = use1;
    pkt.uses_rs2  = use2;
    pkt.is_load   = ld;
    pkt.is_store  = st;
    pkt.is_branch = br;
    pkt.is_jump   = jp;
    pkt.illegal   = ill;
  end

  skid_buffer #(.T(decoded_t)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pkt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pkt)
  );

endmodule
